// File: rtl/solver_result_drainer.sv
// solver_result_drainer
// Sweeps every solver's result memory after a frame is solved (solver id
// outer, address inner). It turns the returned iteration counts into a
// valid/ready pixel stream tagged with source id, address and an
// end-of-frame marker.
// A tag pipeline matches each rd_data beat to the read that produced it.
// A small skid FIFO absorbs read latency and downstream backpressure.
// A credit rule keeps the FIFO from overflowing: reads are issued only while
// FIFO occupancy plus reads in flight is below the FIFO depth.
// Optional build macro: SOLVER_RESULT_DRAINER_COLOR_EN maps each count to an
// RGB332 byte at FIFO push (count >= latched max_iter gives 8'h00).

module solver_result_drainer #(
    parameter int NUM_SOLVERS = 10,
    parameter int ADDR_WIDTH  = 10,
    parameter int ID_WIDTH    = 6,
    parameter int ITER_WIDTH  = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iter,
    output logic [ID_WIDTH-1:0]   rd_solver_id,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ITER_WIDTH-1:0] rd_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [ITER_WIDTH-1:0] pix_data,
    output logic [ID_WIDTH-1:0]   pix_solver_id,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DEPTH = 2 + RD_LATENCY;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ID_WIDTH-1:0]   LAST_ID   = ID_WIDTH'(NUM_SOLVERS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;

    // Read tag pipeline, one entry per cycle of read latency
    logic                  vld_p      [RD_LATENCY];
    logic [ID_WIDTH-1:0]   tag_id_p   [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] tag_addr_p [RD_LATENCY];
    logic                  tag_last_p [RD_LATENCY];

    // Skid FIFO storage and bookkeeping
    logic [ITER_WIDTH-1:0] fifo_data [DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id   [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic                  fifo_last [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic [CNT_W-1:0]      in_flight;
    logic                  credit_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;
    logic [ITER_WIDTH-1:0] push_data;

`ifdef SOLVER_RESULT_DRAINER_COLOR_EN
    logic [ITER_WIDTH-1:0] max_iter_q;

    // RGB332 mapping; counts at or beyond the escape limit are inside the set
    function automatic logic [ITER_WIDTH-1:0] color_map(
        input logic [ITER_WIDTH-1:0] count,
        input logic [ITER_WIDTH-1:0] limit
    );
        logic [ITER_WIDTH-1:0] res;
        res = '0;
        if (count < limit) begin
            res[7:0] = {count[2:0], count[5:3], count[7:6]};
        end
        return res;
    endfunction

    assign push_data = color_map(rd_data, max_iter_q);
`else
    logic unused_max_iter;

    assign unused_max_iter = ^max_iter;
    assign push_data       = rd_data;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Count reads still travelling through the memory latency
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CNT_W'(vld_p[i]);
        end
    end

    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(DEPTH);
    assign issue      = (state == S_ISSUE) && credit_ok;
    assign issue_last = (rd_solver_id == LAST_ID) && (rd_addr == LAST_ADDR);
    assign push       = vld_p[RD_LATENCY-1];
    assign pop        = pix_valid && pix_ready;

    // Control FSM: sweep order, frame bookkeeping and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rd_solver_id <= '0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
`ifdef SOLVER_RESULT_DRAINER_COLOR_EN
            max_iter_q   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef SOLVER_RESULT_DRAINER_COLOR_EN
                        max_iter_q   <= max_iter;
`endif
                        rd_solver_id <= '0;
                        rd_addr      <= '0;
                        busy         <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        if (issue_last) begin
                            state <= S_FLUSH;
                        end else if (rd_addr == LAST_ADDR) begin
                            rd_addr      <= '0;
                            rd_solver_id <= rd_solver_id + ID_WIDTH'(1);
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Finish on the cycle the final entry leaves, so frame_done
                    // follows the last acceptance by exactly one cycle.
                    if ((in_flight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage p0..pN: tag valid bits, cleared on reset to discard in-flight reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Stage p0..pN: tag payload follows its valid bit, no reset needed
    always_ff @(posedge clock) begin
        tag_id_p[0]   <= rd_solver_id;
        tag_addr_p[0] <= rd_addr;
        tag_last_p[0] <= issue_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_id_p[i]   <= tag_id_p[i-1];
            tag_addr_p[i] <= tag_addr_p[i-1];
            tag_last_p[i] <= tag_last_p[i-1];
        end
    end

    // Skid FIFO: storage is cleared on reset so the pix_* outputs start at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_id[i]   <= '0;
                fifo_addr[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_id[wr_ptr]   <= tag_id_p[RD_LATENCY-1];
                fifo_addr[wr_ptr] <= tag_addr_p[RD_LATENCY-1];
                fifo_last[wr_ptr] <= tag_last_p[RD_LATENCY-1];
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // The credit rule must keep a push from ever landing on a full FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(push && !pop && (fifo_count == CNT_W'(DEPTH))));
        end
    end

    assign pix_valid     = (fifo_count != '0);
    assign pix_data      = fifo_data[rd_ptr];
    assign pix_solver_id = fifo_id[rd_ptr];
    assign pix_addr      = fifo_addr[rd_ptr];
    assign pix_last      = fifo_last[rd_ptr];

endmodule

// File: tb/tb_solver_result_drainer.sv
// Bench for solver_result_drainer: two instances (RD_LATENCY 1 and 2) share
// stimulus. A behavioural memory model feeds each instance's rd_data. A
// negedge monitor collects accepted entries, which are compared with the
// expected frame built from the result table.
module tb_solver_result_drainer;

    localparam int NS      = 2;
    localparam int AW      = 3;
    localparam int IDW     = 6;
    localparam int IW      = 16;
    localparam int NI      = 2;
    localparam int ENTRIES = NS * (1 << AW);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  a;
        logic [IW-1:0]  d;
        logic           l;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [IW-1:0] max_iter = '1;

    logic [IDW-1:0] rsid   [NI];
    logic [AW-1:0]  raddr  [NI];
    logic [IW-1:0]  rdata  [NI];
    logic           pv     [NI];
    logic [IW-1:0]  pd     [NI];
    logic [IDW-1:0] psid   [NI];
    logic [AW-1:0]  pa     [NI];
    logic           pl     [NI];
    logic           busy_o [NI];
    logic           fd     [NI];

    logic [IW-1:0] mem [NS][1 << AW];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int epoch   = 0;
    int start_cyc;
    int stall_out [NI];

    // Monitor state
    ent_t got [NI][$];
    int   acc_cnt [NI];
    int   fd_cnt [NI];
    int   fd_err [NI];
    int   stab_err [NI];
    int   first_cyc [NI];
    int   last_acc_cyc [NI];
    int   max_out [NI];
    logic held_v [NI];
    ent_t held [NI];
    logic pend_fd [NI];
    int   seen_epoch = -1;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [IW-1:0] d1;
        logic [IW-1:0] d2;

        solver_result_drainer #(
            .NUM_SOLVERS(NS),
            .ADDR_WIDTH (AW),
            .ID_WIDTH   (IDW),
            .ITER_WIDTH (IW),
            .RD_LATENCY (g + 1)
        ) dut (
            .clock        (clock),
            .reset        (reset),
            .start        (start),
            .max_iter     (max_iter),
            .rd_solver_id (rsid[g]),
            .rd_addr      (raddr[g]),
            .rd_data      (rdata[g]),
            .pix_valid    (pv[g]),
            .pix_ready    (pix_ready),
            .pix_data     (pd[g]),
            .pix_solver_id(psid[g]),
            .pix_addr     (pa[g]),
            .pix_last     (pl[g]),
            .busy         (busy_o[g]),
            .frame_done   (fd[g])
        );

        // Result memory with g+1 cycles of read latency
        always @(posedge clock) begin
            d1 <= mem[rsid[g][0]][raddr[g]];
            d2 <= d1;
        end

        if (g == 0) begin : g_l1
            assign rdata[g] = d1;
        end else begin : g_l2
            assign rdata[g] = d2;
        end
    end

    // Collect accepted entries and watch handshake rules
    always @(negedge clock) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            for (int k = 0; k < NI; k++) begin
                got[k].delete();
                acc_cnt[k] = 0; fd_cnt[k] = 0; fd_err[k] = 0; stab_err[k] = 0;
                first_cyc[k] = -1; last_acc_cyc[k] = -1; max_out[k] = 0;
                held_v[k] = 1'b0; pend_fd[k] = 1'b0;
            end
        end
        for (int k = 0; k < NI; k++) begin
            ent_t cur;
            int   lin;
            cur.id = psid[k]; cur.a = pa[k]; cur.d = pd[k]; cur.l = pl[k];
            lin = int'(rsid[k]) * (1 << AW) + int'(raddr[k]);
            if (!reset) begin
                held_v[k] = 1'b0;
                pend_fd[k] = 1'b0;
            end else begin
                if (pend_fd[k] && fd[k] !== 1'b1) fd_err[k]++;
                pend_fd[k] = 1'b0;
                if (fd[k] === 1'b1) fd_cnt[k]++;
                if (held_v[k] && (pv[k] !== 1'b1 || cur !== held[k])) stab_err[k]++;
                if (pv[k] === 1'b1 && first_cyc[k] < 0) first_cyc[k] = cyc;
                if (busy_o[k] === 1'b1 && lin < ENTRIES - 1 && (lin - acc_cnt[k]) > max_out[k])
                    max_out[k] = lin - acc_cnt[k];
                if (pv[k] === 1'b1 && pix_ready === 1'b1) begin
                    got[k].push_back(cur);
                    acc_cnt[k]++;
                    last_acc_cyc[k] = cyc;
                    held_v[k] = 1'b0;
                    if (pl[k] === 1'b1) pend_fd[k] = 1'b1;
                end else if (pv[k] === 1'b1) begin
                    held_v[k] = 1'b1;
                    held[k] = cur;
                end else begin
                    held_v[k] = 1'b0;
                end
            end
        end
    end

    // Reference pixel value for a raw count
    function automatic logic [IW-1:0] model_pix(input logic [IW-1:0] c);
`ifdef SOLVER_RESULT_DRAINER_COLOR_EN
        logic [IW-1:0] r;
        r = '0;
        if (c < max_iter) r[7:0] = {c[2:0], c[5:3], c[7:6]};
        return r;
`else
        return c;
`endif
    endfunction

    // Entry i of a frame in drain order: solver id outer, address inner
    function automatic ent_t exp_entry(input int i);
        ent_t e;
        int   id;
        int   a;
        id = i / (1 << AW);
        a  = i % (1 << AW);
        e.id = IDW'(id);
        e.a  = AW'(a);
        e.d  = model_pix(mem[id][a]);
        e.l  = (i == ENTRIES - 1);
        return e;
    endfunction

    task automatic fill_random;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < (1 << AW); j++)
                mem[i][j] = IW'($urandom);
    endtask

    // Drive one frame: mode 0 ready high, 1 toggling with a 5-cycle stall,
    // 2 random ready. restart_at >= 0 pulses start again at that entry count.
    task automatic run_frame(input int mode, input int restart_at, output int timed_out);
        int   extra;
        int   stall_left;
        logic stall_done;
        logic need_grab;
        logic restarted;
        epoch++;
        @(negedge clock);
        @(posedge clock); #1;
        pix_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start_cyc = cyc;
        start = 1'b0;
        timed_out = 1; extra = -1; stall_left = 0;
        stall_done = 1'b0; need_grab = 1'b0; restarted = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && acc_cnt[0] >= restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            case (mode)
                0: pix_ready = 1'b1;
                1: begin
                    if (stall_left > 0) begin
                        pix_ready = 1'b0;
                        stall_left--;
                    end else if (need_grab) begin
                        for (int k = 0; k < NI; k++)
                            stall_out[k] = int'(rsid[k]) * (1 << AW) + int'(raddr[k]) - acc_cnt[k];
                        need_grab = 1'b0;
                        pix_ready = 1'b1;
                    end else if (!stall_done && acc_cnt[0] >= 4) begin
                        stall_done = 1'b1;
                        need_grab = 1'b1;
                        stall_left = 4;
                        pix_ready = 1'b0;
                    end else begin
                        pix_ready = ~pix_ready;
                    end
                end
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (extra < 0 && fd_cnt[0] > 0 && fd_cnt[1] > 0) extra = 4;
            if (extra == 0) begin
                timed_out = 0;
                break;
            end
            if (extra > 0) extra--;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if ({rsid[k], raddr[k], pv[k], pd[k], psid[k], pa[k], pl[k], busy_o[k], fd[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_values inst=%0d got=%h want=0", k,
                         {rsid[k], raddr[k], pv[k], pd[k], psid[k], pa[k], pl[k], busy_o[k], fd[k]});
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_sweep;
        int to;
        ent_t e;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < (1 << AW); j++)
                mem[i][j] = IW'(j + 8 * i);
        max_iter = '1;
        run_frame(0, -1, to);
        n_tests++;
        if (to != 0) begin n_fail++; $display("FAIL basic_timeout got=%0d want=0", to); end
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (got[k].size() != ENTRIES) begin
                n_fail++; $display("FAIL basic_count inst=%0d got=%0d want=%0d", k, got[k].size(), ENTRIES);
            end
            for (int i = 0; i < ENTRIES && i < got[k].size(); i++) begin
                e = exp_entry(i);
                n_tests++;
                if (got[k][i] !== e) begin
                    n_fail++; $display("FAIL basic_entry inst=%0d i=%0d got=%h want=%h", k, i, got[k][i], e);
                end
            end
            n_tests++;
            if (first_cyc[k] - start_cyc != k + 2) begin
                n_fail++; $display("FAIL basic_first_latency inst=%0d got=%0d want=%0d", k, first_cyc[k] - start_cyc, k + 2);
            end
            n_tests++;
            if (last_acc_cyc[k] - first_cyc[k] != ENTRIES - 1) begin
                n_fail++; $display("FAIL basic_throughput inst=%0d got=%0d want=%0d", k, last_acc_cyc[k] - first_cyc[k], ENTRIES - 1);
            end
            n_tests++;
            if (fd_cnt[k] != 1 || fd_err[k] != 0) begin
                n_fail++; $display("FAIL basic_frame_done inst=%0d got cnt=%0d late=%0d want 1/0", k, fd_cnt[k], fd_err[k]);
            end
            n_tests++;
            if (busy_o[k] !== 1'b0) begin
                n_fail++; $display("FAIL basic_busy_after inst=%0d got=%b want=0", k, busy_o[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        int to;
        ent_t e;
        fill_random();
        run_frame(1, -1, to);
        n_tests++;
        if (to != 0) begin n_fail++; $display("FAIL bp_timeout got=%0d want=0", to); end
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (got[k].size() != ENTRIES) begin
                n_fail++; $display("FAIL bp_count inst=%0d got=%0d want=%0d", k, got[k].size(), ENTRIES);
            end
            for (int i = 0; i < ENTRIES && i < got[k].size(); i++) begin
                e = exp_entry(i);
                n_tests++;
                if (got[k][i] !== e) begin
                    n_fail++; $display("FAIL bp_entry inst=%0d i=%0d got=%h want=%h", k, i, got[k][i], e);
                end
            end
            n_tests++;
            if (stab_err[k] != 0) begin
                n_fail++; $display("FAIL bp_stable inst=%0d got=%0d want=0", k, stab_err[k]);
            end
            n_tests++;
            if (stall_out[k] != k + 3) begin
                n_fail++; $display("FAIL bp_outstanding inst=%0d got=%0d want=%0d", k, stall_out[k], k + 3);
            end
            n_tests++;
            if (fd_cnt[k] != 1 || fd_err[k] != 0) begin
                n_fail++; $display("FAIL bp_frame_done inst=%0d got cnt=%0d late=%0d want 1/0", k, fd_cnt[k], fd_err[k]);
            end
        end
    endtask

    task automatic test_random_ready;
        int to;
        ent_t e;
        for (int rep = 0; rep < 2; rep++) begin
            fill_random();
            run_frame(2, -1, to);
            n_tests++;
            if (to != 0) begin n_fail++; $display("FAIL rnd_timeout got=%0d want=0", to); end
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (got[k].size() != ENTRIES) begin
                    n_fail++; $display("FAIL rnd_count inst=%0d got=%0d want=%0d", k, got[k].size(), ENTRIES);
                end
                for (int i = 0; i < ENTRIES && i < got[k].size(); i++) begin
                    e = exp_entry(i);
                    n_tests++;
                    if (got[k][i] !== e) begin
                        n_fail++; $display("FAIL rnd_entry inst=%0d i=%0d got=%h want=%h", k, i, got[k][i], e);
                    end
                end
                n_tests++;
                if (max_out[k] > k + 3 || stab_err[k] != 0) begin
                    n_fail++; $display("FAIL rnd_occupancy inst=%0d got max=%0d unstable=%0d want <=%0d/0", k, max_out[k], stab_err[k], k + 3);
                end
            end
        end
    endtask

    task automatic test_start_while_busy;
        int to;
        fill_random();
        run_frame(0, 5, to);
        n_tests++;
        if (to != 0) begin n_fail++; $display("FAIL busy_start_timeout got=%0d want=0", to); end
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (got[k].size() != ENTRIES || fd_cnt[k] != 1) begin
                n_fail++; $display("FAIL busy_start inst=%0d got entries=%0d done=%0d want %0d/1", k, got[k].size(), fd_cnt[k], ENTRIES);
            end
            n_tests++;
            if (got[k].size() > 5 && got[k][5] !== exp_entry(5)) begin
                n_fail++; $display("FAIL busy_start_entry5 inst=%0d got=%h want=%h", k, got[k][5], exp_entry(5));
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int   to;
        logic reached;
        ent_t e;
        fill_random();
        epoch++;
        @(negedge clock);
        pix_ready = 1'b1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        reached = 1'b0;
        for (int it = 0; it < 200; it++) begin
            @(negedge clock);
            if (acc_cnt[0] >= 9) begin reached = 1'b1; break; end
        end
        n_tests++;
        if (!reached) begin n_fail++; $display("FAIL mid_reset_reach got=%0d want>=9", acc_cnt[0]); end
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if ({rsid[k], raddr[k], pv[k], pd[k], psid[k], pa[k], pl[k], busy_o[k], fd[k]} !== '0) begin
                n_fail++;
                $display("FAIL mid_reset_async inst=%0d got=%h want=0", k,
                         {rsid[k], raddr[k], pv[k], pd[k], psid[k], pa[k], pl[k], busy_o[k], fd[k]});
            end
        end
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        run_frame(0, -1, to);
        n_tests++;
        if (to != 0) begin n_fail++; $display("FAIL mid_reset_timeout got=%0d want=0", to); end
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (got[k].size() != ENTRIES || fd_cnt[k] != 1) begin
                n_fail++; $display("FAIL mid_reset_frame inst=%0d got entries=%0d done=%0d want %0d/1", k, got[k].size(), fd_cnt[k], ENTRIES);
            end
            for (int i = 0; i < ENTRIES && i < got[k].size(); i++) begin
                e = exp_entry(i);
                n_tests++;
                if (got[k][i] !== e) begin
                    n_fail++; $display("FAIL mid_reset_entry inst=%0d i=%0d got=%h want=%h", k, i, got[k][i], e);
                end
            end
        end
    endtask

    task automatic test_color_map;
        int            to;
        logic [IW-1:0] want0;
        logic [IW-1:0] want1;
        fill_random();
        mem[0][0] = 16'd100;
        mem[0][1] = 16'h002D;
        max_iter  = 16'd100;
`ifdef SOLVER_RESULT_DRAINER_COLOR_EN
        want0 = 16'h0000;   // at the limit: inside the set
        want1 = 16'h00B4;   // 0x2D -> {101,101,00}
`else
        want0 = 16'h0064;
        want1 = 16'h002D;
`endif
        run_frame(0, -1, to);
        n_tests++;
        if (to != 0) begin n_fail++; $display("FAIL color_timeout got=%0d want=0", to); end
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (got[k].size() < 2 || got[k][0].d !== want0 || got[k][1].d !== want1) begin
                n_fail++;
                $display("FAIL color_values inst=%0d got n=%0d d0=%h d1=%h want %h %h", k, got[k].size(),
                         (got[k].size() > 0) ? got[k][0].d : 16'hxxxx,
                         (got[k].size() > 1) ? got[k][1].d : 16'hxxxx, want0, want1);
            end
        end
        max_iter = '1;
    endtask

    initial begin
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < (1 << AW); j++)
                mem[i][j] = '0;
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid_frame();
        test_color_map();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
